// File: rtl/ccff_bitstream_loader.sv
// Configuration-chain loader: takes bitstream words on a valid/ready stream and
// shifts exactly CHAIN_LEN bits MSB-first into ccff_head, counting ones seen on ccff_tail.
module ccff_bitstream_loader #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned CHAIN_LEN = 8
) (
  input  logic                               prog_clk,
  input  logic                               pReset,
  input  logic                               start,
  input  logic [DATA_W-1:0]                  bs_data,
  input  logic                               bs_valid,
  output logic                               bs_ready,
  output logic                               ccff_head,
  output logic                               ccff_en,
  input  logic                               ccff_tail,
  output logic                               busy,
  output logic                               done,
  output logic [$clog2(CHAIN_LEN+1)-1:0]     tail_ones
);

  localparam int unsigned CNT_W  = $clog2(CHAIN_LEN + 1);
  localparam int unsigned REM_W  = $clog2(DATA_W + 1);
  localparam int unsigned WORDS  = (CHAIN_LEN + DATA_W - 1) / DATA_W;
  localparam int unsigned WCNT_W = $clog2(WORDS + 1);

  localparam logic [CNT_W-1:0]  LAST_SHIFT = CNT_W'(CHAIN_LEN - 1);
  localparam logic [REM_W-1:0]  REM_FULL   = REM_W'(DATA_W);
  localparam logic [REM_W-1:0]  REM_ONE    = REM_W'(1);
  localparam logic [WCNT_W-1:0] WORDS_C    = WCNT_W'(WORDS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [DATA_W-1:0]   hold;
  logic [REM_W-1:0]    rem;
  logic [CNT_W-1:0]    shifted;
  logic [WCNT_W-1:0]   words_got;
  logic                accept;
  logic                last_shift;

  // State register
  always_ff @(posedge prog_clk) begin
    if (pReset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next state and combinational handshake / shift controls
  always_comb begin
    state_nxt  = state;
    ccff_en    = 1'b0;
    ccff_head  = 1'b0;
    bs_ready   = 1'b0;
    accept     = 1'b0;
    last_shift = 1'b0;

    ccff_en    = (state == S_LOAD) && (rem != '0);
    ccff_head  = ccff_en && hold[DATA_W-1];
    // Refill either when empty or on the edge that drains the last bit, so words stream without bubbles
    bs_ready   = (state == S_LOAD) && (words_got != WORDS_C) &&
                 ((rem == '0) || ((rem == REM_ONE) && ccff_en));
    accept     = bs_valid && bs_ready;
    last_shift = ccff_en && (shifted == LAST_SHIFT);

    unique case (state)
      S_IDLE:  if (start) state_nxt = S_LOAD;
      S_LOAD:  if (last_shift) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath: holding register, counters and status flags
  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      hold      <= '0;
      rem       <= '0;
      shifted   <= '0;
      words_got <= '0;
      tail_ones <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      busy <= (state_nxt == S_LOAD);
      done <= (state_nxt == S_DONE);
      if ((state == S_IDLE) && start) begin
        hold      <= '0;
        rem       <= '0;
        shifted   <= '0;
        words_got <= '0;
        tail_ones <= '0;
      end else begin
        if (accept) begin
          hold      <= bs_data;
          rem       <= REM_FULL;
          words_got <= words_got + WCNT_W'(1);
        end else if (ccff_en) begin
          hold <= hold << 1;
          // A partial final word has its unused low bits discarded here
          rem  <= last_shift ? '0 : (rem - REM_ONE);
        end
        if (ccff_en) begin
          shifted   <= shifted + CNT_W'(1);
          tail_ones <= tail_ones + CNT_W'(ccff_tail);
        end
      end
    end
  end

endmodule
